// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states, MMIO map, wait-counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] MMIO_OUT_ADDR = 8'hFF;
    localparam logic [7:0] MMIO_IN_ADDR  = 8'hFE;

    localparam int unsigned WC_W = 4;

endpackage

// File: rtl/mem_store.sv
// Byte store for the responder: synchronous write, combinational read, contents never cleared.
module mem_store #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// MemRead/MemWrite responder with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Define MEM_MMIO_EN to map 0xFF to the io_out register and 0xFE to the sw_in switches.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              ready,
    output logic              busy,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] io_out
);

    state_t            state_q, state_d;
    logic [WC_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              store_we;
    logic [DATA_W-1:0] store_rdata;

`ifdef MEM_MMIO_EN
    logic [DATA_W-1:0] io_q, io_d;
`endif

    mem_store #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_store (
        .clock (clock),
        .we    (store_we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (store_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            q_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;
        q_d      = q_q;
        ready_d  = 1'b0;
        busy_d   = busy_q;
        store_we = 1'b0;
`ifdef MEM_MMIO_EN
        io_d     = io_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = address;
                    data_d  = data;
                    wr_d    = MemWrite; // write wins over a simultaneous read
                    busy_d  = 1'b1;
                    count_d = WC_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                count_d = count_q - 1'b1;
                if (count_q == WC_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef MEM_MMIO_EN
                if (addr_q == ADDR_W'(MMIO_OUT_ADDR)) begin
                    if (wr_q) io_d = data_q;
                    else      q_d  = io_q;
                end else if (addr_q == ADDR_W'(MMIO_IN_ADDR)) begin
                    if (!wr_q) q_d = sw_in;
                end else begin
                    if (wr_q) store_we = 1'b1;
                    else      q_d      = store_rdata;
                end
`else
                if (wr_q) store_we = 1'b1;
                else      q_d      = store_rdata;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_MMIO_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) io_q <= '0;
        else       io_q <= io_d;
    end
    assign io_out = io_q;
`else
    logic unused_sw;
    assign unused_sw = ^sw_in;
    assign io_out    = '0;
`endif

    assign q     = q_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0, scoreboarded read data.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd  [2];
    logic       wr  [2];
    logic [7:0] ad  [2];
    logic [7:0] dt  [2];
    logic [7:0] q   [2];
    logic       rdy [2];
    logic       bsy [2];
    logic [7:0] io  [2];
    logic [7:0] sw;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [2][256];
    logic [7:0] io_m  [2];
    logic [7:0] last_q[2];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .clock(clk), .reset(rst), .MemRead(rd[0]), .MemWrite(wr[0]),
        .address(ad[0]), .data(dt[0]), .q(q[0]), .ready(rdy[0]), .busy(bsy[0]),
        .sw_in(sw), .io_out(io[0])
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst), .MemRead(rd[1]), .MemWrite(wr[1]),
        .address(ad[1]), .data(dt[1]), .q(q[1]), .ready(rdy[1]), .busy(bsy[1]),
        .sw_in(sw), .io_out(io[1])
    );

    function automatic int wait_of(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] read_exp(int i, logic [7:0] a);
`ifdef MEM_MMIO_EN
        if (a == 8'hFF) return io_m[i];
        if (a == 8'hFE) return sw;
`endif
        return model[i][a];
    endfunction

    task automatic access(input int i, input logic r, input logic w,
                          input logic [7:0] a, input logic [7:0] d, input bit hold);
        int         lat;
        bit         done;
        logic [7:0] e;
        logic [7:0] got;
        @(negedge clk);
        rd[i] = r; wr[i] = w; ad[i] = a; dt[i] = d;
        e = (r && !w) ? read_exp(i, a) : last_q[i];
        if (w) begin
`ifdef MEM_MMIO_EN
            if (a == 8'hFF)      io_m[i] = d;
            else if (a != 8'hFE) model[i][a] = d;
`else
            model[i][a] = d;
`endif
        end
        last_q[i] = e;
        exp_q.push_back(e);
        @(posedge clk); #1;
        n_checks++;
        if (bsy[i] !== 1'b1 || rdy[i] !== 1'b0)
            $display("FAIL accept inst%0d: busy=%b ready=%b, want busy=1 ready=0", i, bsy[i], rdy[i]);
        @(negedge clk);
        ad[i] = 8'($urandom); dt[i] = 8'($urandom);
        if (!hold) begin rd[i] = 1'b0; wr[i] = 1'b0; end
        lat = 0; done = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy[i] === 1'b1) done = 1;
            else begin
                n_checks++;
                if (bsy[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_wait inst%0d: busy=%b at edge %0d, want 1", i, bsy[i], lat);
                end
            end
        end
        got = exp_q.pop_front();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout inst%0d: no ready within %0d edges", i, lat);
        end else begin
            if (lat != wait_of(i) + 1) begin
                n_fail++;
                $display("FAIL latency inst%0d: ready after %0d edges, want %0d", i, lat, wait_of(i) + 1);
            end
            n_checks++;
            if (bsy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_done inst%0d: busy=%b with ready, want 0", i, bsy[i]);
            end
            n_checks++;
            if (q[i] !== got) begin
                n_fail++;
                $display("FAIL q inst%0d addr=%h: q=%h, want %h", i, a, q[i], got);
            end
        end
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rdy[i] !== 1'b0 || bsy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse inst%0d: ready=%b busy=%b after pulse, want 0 0", i, rdy[i], bsy[i]);
        end
        n_checks++;
        if (io[i] !== io_m[i]) begin
            n_fail++;
            $display("FAIL io_out inst%0d: io_out=%h, want %h", i, io[i], io_m[i]);
        end
    endtask

    task automatic test_reset;
        sw = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; dt[i] = '0;
            io_m[i] = '0; last_q[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({q[i], rdy[i], bsy[i], io[i]} !== 18'h0) begin
                    n_fail++;
                    $display("FAIL reset_idle inst%0d: q=%h ready=%b busy=%b io=%h, want all 0",
                             i, q[i], rdy[i], bsy[i], io[i]);
                end
            end
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 2; i++) begin
            access(i, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0);
            access(i, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        end
    endtask

    task automatic test_simultaneous_and_busy;
        for (int i = 0; i < 2; i++) begin
            access(i, 1'b1, 1'b1, 8'h20, 8'h33, 1'b1);
            access(i, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] addrs[6];
        for (int k = 0; k < 6; k++) addrs[k] = 8'(k * 37 + 1);
        addrs[0] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            foreach (addrs[k]) access(i, 1'b0, 1'b1, addrs[k], 8'($urandom), 1'b0);
            foreach (addrs[k]) access(i, 1'b1, 1'b0, addrs[k], 8'h00, 1'b0);
        end
    endtask

    task automatic test_reset_abort;
        access(0, 1'b0, 1'b1, 8'h30, 8'h11, 1'b0);
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 8'h30; dt[0] = 8'h77;
        @(posedge clk); #1;
        @(negedge clk);
        wr[0] = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || q[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL abort: ready=%b busy=%b q=%h, want 0 0 00", rdy[0], bsy[0], q[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin io_m[i] = '0; last_q[i] = '0; end
        access(0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    endtask

    task automatic test_mmio;
        for (int i = 0; i < 2; i++) begin
            access(i, 1'b0, 1'b1, 8'hFE, 8'hA5, 1'b0);
            access(i, 1'b0, 1'b1, 8'hFF, 8'hC3, 1'b0);
            sw = 8'h1F;
            access(i, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b0);
            access(i, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
            sw = 8'h00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_simultaneous_and_busy();
        test_back_to_back();
        test_reset_abort();
        test_mmio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
